// File: rtl/muxn_reg.sv
`default_nettype none
// ============================================================================
//  Module      : muxn_reg
//  Description : N-channel registered multiplexer with per-channel valid/ready,
//                direct-select or round-robin arbitration, one output register.
//  Revision    : 1.0 - initial release
// ============================================================================
module muxn_reg #(
    parameter  int DATA_WITH = 12,
    parameter  int NUM_CH    = 4,
    localparam int SEL_W     = $clog2(NUM_CH)
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic [NUM_CH*DATA_WITH-1:0]   i_data,
    input  logic [NUM_CH-1:0]             i_valid,
    output logic [NUM_CH-1:0]             o_ready,
    input  logic                          i_mode,
    input  logic [SEL_W-1:0]              i_sel,
    output logic [DATA_WITH-1:0]          o_data,
    output logic                          o_valid,
    output logic [SEL_W-1:0]              o_ch,
    input  logic                          i_ready
);

    // One extra bit so pointer+offset sums never overflow before wrapping.
    localparam logic [SEL_W:0] c_num_ch = (SEL_W+1)'(NUM_CH);

    logic [DATA_WITH-1:0] r_data;
    logic                 r_valid;
    logic [SEL_W-1:0]     r_ch;
    logic [SEL_W-1:0]     r_ptr;

    logic [DATA_WITH-1:0] w_ch_data [NUM_CH];
    logic [DATA_WITH-1:0] w_pick_data;
    logic                 w_rr_hit;
    logic [SEL_W-1:0]     w_rr_ch;
    logic                 w_sel_ok;
    logic                 w_pick_vld;
    logic [SEL_W-1:0]     w_pick;
    logic                 w_load;
    logic                 w_grant;
    logic                 w_xfer;

    function automatic logic [SEL_W-1:0] rr_index(input logic [SEL_W-1:0] ptr,
                                                  input logic [SEL_W:0]   off);
        logic [SEL_W:0] sum;
        sum = {1'b0, ptr} + off;
        if (sum >= c_num_ch)
            sum = sum - c_num_ch;
        return sum[SEL_W-1:0];
    endfunction

    function automatic logic [SEL_W-1:0] wrap_inc(input logic [SEL_W-1:0] ch);
        logic [SEL_W:0] sum;
        sum = {1'b0, ch} + (SEL_W+1)'(1);
        return (sum == c_num_ch) ? '0 : sum[SEL_W-1:0];
    endfunction

    generate
        for (genvar k = 0; k < NUM_CH; k++) begin : g_unpack
            assign w_ch_data[k] = i_data[k*DATA_WITH +: DATA_WITH];
        end
    endgenerate

    // First valid channel at or after the pointer, wrapping around.
    always_comb begin
        w_rr_hit = 1'b0;
        w_rr_ch  = '0;
        for (int j = 0; j < NUM_CH; j++) begin
            if (!w_rr_hit && i_valid[rr_index(r_ptr, (SEL_W+1)'(j))]) begin
                w_rr_hit = 1'b1;
                w_rr_ch  = rr_index(r_ptr, (SEL_W+1)'(j));
            end
        end
    end

    assign w_sel_ok   = ({1'b0, i_sel} < c_num_ch);
    assign w_pick_vld = i_mode ? w_rr_hit : w_sel_ok;
    assign w_pick     = i_mode ? w_rr_ch  : i_sel;
    assign w_load     = !r_valid || i_ready;
    assign w_grant    = i_rst_n && w_load && w_pick_vld;

    generate
        for (genvar k = 0; k < NUM_CH; k++) begin : g_ready
            assign o_ready[k] = w_grant && (w_pick == SEL_W'(k));
        end
    endgenerate

    assign w_xfer = |(o_ready & i_valid);

    always_comb begin
        w_pick_data = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (w_pick == SEL_W'(k))
                w_pick_data = w_ch_data[k];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ch    <= '0;
            r_ptr   <= '0;
        end else if (w_xfer) begin
            r_data  <= w_pick_data;
            r_ch    <= w_pick;
            r_valid <= 1'b1;
            if (i_mode)
                r_ptr <= wrap_inc(w_pick);
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;
    assign o_ch    = r_ch;

endmodule
`default_nettype wire

// File: tb/tb_muxn_reg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_muxn_reg
//  Description : Directed + random bench for muxn_reg (4- and 3-channel builds)
//                against a transaction-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_muxn_reg;

    logic i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    logic rst_n;

    logic [47:0] d4_data;
    logic [3:0]  d4_valid, d4_oready;
    logic        d4_mode, d4_ovalid, d4_iready;
    logic [1:0]  d4_sel, d4_och;
    logic [11:0] d4_odata;

    logic [35:0] d3_data;
    logic [2:0]  d3_valid, d3_oready;
    logic        d3_mode, d3_ovalid, d3_iready;
    logic [1:0]  d3_sel, d3_och;
    logic [11:0] d3_odata;

    muxn_reg #(.DATA_WITH(12), .NUM_CH(4)) dut4 (
        .i_clk(i_clk), .i_rst_n(rst_n), .i_data(d4_data), .i_valid(d4_valid),
        .o_ready(d4_oready), .i_mode(d4_mode), .i_sel(d4_sel), .o_data(d4_odata),
        .o_valid(d4_ovalid), .o_ch(d4_och), .i_ready(d4_iready)
    );

    muxn_reg #(.DATA_WITH(12), .NUM_CH(3)) dut3 (
        .i_clk(i_clk), .i_rst_n(rst_n), .i_data(d3_data), .i_valid(d3_valid),
        .o_ready(d3_oready), .i_mode(d3_mode), .i_sel(d3_sel), .o_data(d3_odata),
        .o_valid(d3_ovalid), .o_ch(d3_och), .i_ready(d3_iready)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: contents of the output register and the RR pointer.
    bit          m_valid [2];
    logic [11:0] m_data  [2];
    int          m_ch    [2];
    int          m_ptr   [2];
    bit          n_valid [2];
    logic [11:0] n_data  [2];
    int          n_ch    [2];
    int          n_ptr   [2];

    int rr_seq[6];
    int wrap_seq[4];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int pick(input int nch, input bit mode, input int sel,
                                input logic [15:0] vin, input int ptr);
        if (!mode)
            return (sel < nch) ? sel : -1;
        for (int j = 0; j < nch; j++) begin
            int k = (ptr + j) % nch;
            if (vin[k]) return k;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_valid[i] = 0; m_data[i] = '0; m_ch[i] = 0; m_ptr[i] = 0;
        end
    endtask

    task automatic eval(input int id);
        int nch, sel, och, c;
        bit mode, ov, irdy, load;
        logic [15:0] vin, rdy, exp_rdy;
        logic [11:0] od;
        logic [11:0] words [4];
        string p;
        if (id == 0) begin
            nch = 4; mode = d4_mode; sel = int'(d4_sel); vin = 16'(d4_valid);
            rdy = 16'(d4_oready); od = d4_odata; ov = d4_ovalid; och = int'(d4_och);
            irdy = d4_iready; p = "n4";
            for (int k = 0; k < 4; k++) words[k] = d4_data[k*12 +: 12];
        end else begin
            nch = 3; mode = d3_mode; sel = int'(d3_sel); vin = 16'(d3_valid);
            rdy = 16'(d3_oready); od = d3_odata; ov = d3_ovalid; och = int'(d3_och);
            irdy = d3_iready; p = "n3";
            for (int k = 0; k < 3; k++) words[k] = d3_data[k*12 +: 12];
            words[3] = '0;
        end
        load    = !m_valid[id] || irdy;
        c       = pick(nch, mode, sel, vin, m_ptr[id]);
        exp_rdy = (rst_n && load && c >= 0) ? (16'(1) << c) : 16'(0);
        chk({p, "_valid"}, 32'(ov),  32'(m_valid[id]));
        chk({p, "_data"},  32'(od),  32'(m_data[id]));
        chk({p, "_ch"},    32'(och), 32'(m_ch[id]));
        chk({p, "_ready"}, 32'(rdy), 32'(exp_rdy));
        n_valid[id] = m_valid[id]; n_data[id] = m_data[id];
        n_ch[id] = m_ch[id]; n_ptr[id] = m_ptr[id];
        if (!rst_n) begin
            n_valid[id] = 0; n_data[id] = '0; n_ch[id] = 0; n_ptr[id] = 0;
        end else if (c >= 0 && exp_rdy[c] && vin[c]) begin
            n_valid[id] = 1; n_data[id] = words[c]; n_ch[id] = c;
            if (mode) n_ptr[id] = (c + 1) % nch;
        end else if (m_valid[id] && irdy) begin
            n_valid[id] = 0;
        end
    endtask

    task automatic tick();
        #1;
        eval(0);
        eval(1);
        @(posedge i_clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            m_valid[i] = n_valid[i]; m_data[i] = n_data[i];
            m_ch[i] = n_ch[i]; m_ptr[i] = n_ptr[i];
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rr_seq   = '{0, 1, 2, 3, 0, 1};
        wrap_seq = '{0, 3, 0, 3};
        rst_n = 1'b0;
        d4_data = '0; d4_valid = '0; d4_mode = 1'b0; d4_sel = '0; d4_iready = 1'b1;
        d3_data = '0; d3_valid = '0; d3_mode = 1'b0; d3_sel = '0; d3_iready = 1'b1;
        model_reset();
        @(posedge i_clk);
        #1;
        tick();
        chk("rst_valid", 32'(d4_ovalid), 32'(0));
        chk("rst_ready", 32'(d4_oready), 32'(0));
        rst_n = 1'b1;

        // Direct select of channel 2, then asynchronous reset mid-cycle
        d4_mode = 1'b0; d4_sel = 2'd2; d4_valid = 4'b0100; d4_iready = 1'b1;
        d4_data = '0; d4_data[35:24] = 12'hA5C;
        #1;
        chk("t1_ready", 32'(d4_oready), 32'(4'b0100));
        tick();
        chk("t1_valid", 32'(d4_ovalid), 32'(1));
        chk("t1_data",  32'(d4_odata),  32'(12'hA5C));
        chk("t1_ch",    32'(d4_och),    32'(2));
        d4_valid = '0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("t1_arst_valid", 32'(d4_ovalid), 32'(0));
        chk("t1_arst_data",  32'(d4_odata),  32'(0));
        chk("t1_arst_ch",    32'(d4_och),    32'(0));
        chk("t1_arst_ready", 32'(d4_oready), 32'(0));
        model_reset();
        rst_n = 1'b1;

        // Backpressure on a channel-1 stream
        d4_sel = 2'd1; d4_valid = 4'b0010; d4_data = '0; d4_data[23:12] = 12'd1;
        tick();
        d4_data[23:12] = 12'd2; d4_iready = 1'b0;
        repeat (3) begin
            tick();
            chk("t2_hold_data",  32'(d4_odata),  32'(1));
            chk("t2_hold_ready", 32'(d4_oready), 32'(0));
        end
        d4_iready = 1'b1;
        tick();
        chk("t2_beat2", 32'(d4_odata), 32'(2));
        d4_data[23:12] = 12'd3;
        tick();
        chk("t2_beat3", 32'(d4_odata), 32'(3));
        d4_valid = '0;
        tick();
        chk("t2_drain", 32'(d4_ovalid), 32'(0));

        // Round-robin fairness with every channel valid
        do_reset();
        d4_mode = 1'b1; d4_valid = 4'b1111; d4_iready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            d4_data = {16'($urandom), 32'($urandom)};
            tick();
            chk("t3_rr_ch", 32'(d4_och), 32'(rr_seq[i]));
        end

        // Round-robin skip and wrap, then idle drain
        do_reset();
        d4_mode = 1'b1; d4_valid = 4'b1001; d4_iready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t4_wrap_ch", 32'(d4_och), 32'(wrap_seq[i]));
        end
        d4_valid = '0;
        #1;
        chk("t4_idle_ready", 32'(d4_oready), 32'(0));
        tick();
        chk("t4_idle_valid", 32'(d4_ovalid), 32'(0));

        // Mode switch while stalled keeps the held word and the pointer
        do_reset();
        d4_mode = 1'b1; d4_valid = 4'b1111; d4_iready = 1'b1;
        d4_data = {12'h444, 12'h333, 12'h222, 12'h111};
        tick();
        tick();
        d4_iready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            d4_mode = 1'(i % 2 == 0 ? 0 : 1);
            d4_sel  = 2'($urandom);
            d4_data = {16'($urandom), 32'($urandom)};
            tick();
            chk("t6_hold_ch",   32'(d4_och),   32'(1));
            chk("t6_hold_data", 32'(d4_odata), 32'(12'h222));
        end
        d4_mode = 1'b1; d4_iready = 1'b1; d4_valid = 4'b1111;
        tick();
        chk("t6_ptr_kept", 32'(d4_och), 32'(2));

        // Out-of-range select on the 3-channel build
        do_reset();
        d4_valid = '0;
        d3_mode = 1'b0; d3_sel = 2'd3; d3_valid = 3'b111; d3_iready = 1'b1;
        d3_data = {4'($urandom), 32'($urandom)};
        repeat (4) begin
            tick();
            chk("t5_ready", 32'(d3_oready), 32'(0));
            chk("t5_valid", 32'(d3_ovalid), 32'(0));
        end

        // Random traffic on both builds
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if (i == 200) do_reset();
            d4_data   = {16'($urandom), 32'($urandom)};
            d4_valid  = 4'($urandom);
            d4_mode   = 1'($urandom);
            d4_sel    = 2'($urandom);
            d4_iready = ($urandom_range(0, 3) != 0);
            d3_data   = {4'($urandom), 32'($urandom)};
            d3_valid  = 3'($urandom);
            d3_mode   = 1'($urandom);
            d3_sel    = 2'($urandom);
            d3_iready = ($urandom_range(0, 3) != 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/muxn_reg.md
Name: muxn_reg

Overview:
- Parametrised successor to the 2:1 mux leaf: N-channel registered multiplexer with valid/ready handshakes on every input channel and on the output.
- Two runtime modes:
  - Direct select: the channel index comes from i_sel.
  - Round-robin: fair arbitration among the valid channels.
- One-entry output register, so there is one cycle of latency and full throughput.
- Sits between bus masters and a shared downstream consumer.

Parameters:
- DATA_WITH, 12, width of each channel's data word.
- NUM_CH, 4, number of input channels (2..16).
- SEL_W, $clog2(NUM_CH), channel index width. Derived; not to be overridden.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst_n  input  1  reset, asynchronous and active-low.
- i_data  input  NUM_CH*DATA_WITH  channel k data at bits [k*DATA_WITH +: DATA_WITH].
- i_valid  input  NUM_CH  per-channel valid.
- o_ready  output  NUM_CH  per-channel ready; combinational.
- i_mode  input  1  0 = direct select, 1 = round-robin.
- i_sel  input  SEL_W  channel index in direct-select mode.
- o_data  output  DATA_WITH  registered output word.
- o_valid  output  1  output register holds a word.
- o_ch  output  SEL_W  source channel of the word in o_data.
- i_ready  input  1  downstream accepts o_data.

Behaviour:
- Reset (asynchronous, whenever i_rst_n=0):
  - o_valid=0, o_data=0, o_ch=0, RR pointer=0.
  - A held word is discarded, even mid-handshake.
  - o_ready is all zero while reset is asserted.
- Load condition: load = !o_valid || i_ready. The register refills in the same cycle it drains, so no bubble on back-to-back traffic.
- Chosen channel c, computed combinationally each cycle:
  - Mode 0: c = i_sel. If i_sel >= NUM_CH, no channel is chosen and o_ready = 0.
  - Mode 1: c = first k with i_valid[k]=1, scanning from the RR pointer p upward and wrapping modulo NUM_CH. No valid channel means no choice.
- o_ready[k] = load && (k == c), so at most one bit is set.
  - Mode 0: o_ready[c] is asserted even if i_valid[c]=0.
  - Mode 1: o_ready is asserted only on a valid channel.
- Transfer: i_valid[c] && o_ready[c]. At the next edge:
  - o_data <= i_data[c].
  - o_ch <= c.
  - o_valid <= 1.
- Drain only (o_valid && i_ready, no transfer): o_valid <= 0. o_data and o_ch hold their last value.
- Stall (o_valid && !i_ready):
  - o_data, o_ch and o_valid hold.
  - o_ready is all zero.
  - Input-side changes are ignored.
- RR pointer:
  - Updated only on a transfer while i_mode=1: p <= (c+1) mod NUM_CH. When c = NUM_CH-1, p wraps to 0.
  - Unchanged in mode 0 and on idle cycles.
- Mode/sel changes:
  - Take effect combinationally the same cycle.
  - Never disturb a word already in the output register.
  - The pointer is retained across mode switches.
- Latency: input transfer to o_valid is exactly 1 cycle. Throughput: 1 word/cycle when i_ready is held high.
- Data is never duplicated or dropped:
  - Each transfer yields exactly one output beat.
  - Each output beat yields exactly one o_valid&&i_ready.
- No arithmetic beyond the modulo-NUM_CH pointer increment. Widths are exact, with no truncation of data.

Test Plan (NUM_CH=4, DATA_WITH=12):
1. Reset then direct select: i_mode=0, i_sel=2, i_valid=4'b0100, i_data ch2=12'hA5C, i_ready=1 -> o_ready=4'b0100. Next cycle: o_valid=1, o_data=12'hA5C, o_ch=2. Assert i_rst_n=0 asynchronously mid-cycle -> all outputs 0 immediately.
2. Backpressure: i_mode=0, i_sel=1, streaming ch1 data 1,2,3; i_ready=0 for 3 cycles after the first beat -> o_data stays 1, o_ready=0. On i_ready=1: 2 then 3 emerge on consecutive cycles, with no loss or duplication.
3. Round-robin fairness: i_mode=1, i_valid=4'b1111 constant, i_ready=1 -> o_ch sequence 0,1,2,3,0,1 on consecutive cycles.
4. Round-robin skip and wrap: i_mode=1, i_valid=4'b1001, p=0 -> grants 0,3,0,3. With i_valid=4'b0000 -> o_ready=0, and o_valid falls after the drain.
5. Invalid select: i_mode=0, i_sel=3 with NUM_CH=3 build -> o_ready=0, and no transfer ever occurs.
6. Mode switch under stall: word held with i_ready=0; toggle i_mode 1->0 and change i_sel -> the held o_data/o_ch are unchanged. The pointer value is preserved when returning to mode 1.
